bendlab_seq_ctrl: RTL and testbench

Instruction sequencer for the Bendlab sensor control path. It drives the 8-bit address of the synchronous instruction ROM (256 × 32-bit words, registered read, 1-cycle latency), fetches and decodes each word, and turns it into byte-level I2C commands, delays or interrupt waits. Read bytes and error/status flags are presented to the rest of the design.

---
 rtl/bendlab_seq_ctrl_if.sv | 21 ++
 rtl/bendlab_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_bendlab_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bendlab_seq_ctrl_if.sv
// Command/response bus between the Bendlab sequencer and the I2C byte engine.
// The sequencer is the master: it issues byte commands and consumes completions.
interface bendlab_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );
endinterface

// File: rtl/bendlab_seq_ctrl.sv
// Bendlab instruction sequencer: fetches 32-bit words from a registered-read ROM,
// decodes them and turns them into I2C byte commands, delays and interrupt waits.
// All outputs are registered; rom_addr and pc are the PC register itself.
module bendlab_seq_ctrl #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      irq,
    output logic [7:0]                rom_addr,
    input  logic [31:0]               rom_data,
    bendlab_seq_ctrl_if.master        eng,
    output logic                      rd_valid,
    output logic [7:0]                rd_data,
    output logic                      busy,
    output logic                      halted,
    output logic                      err_nack,
    output logic                      err_illegal,
    output logic                      err_timeout,
    output logic [7:0]                pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DELAY,
        S_WAIT_IRQ,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_START     = 4'd1;
    localparam logic [3:0] OP_WRITE     = 4'd2;
    localparam logic [3:0] OP_READ_ACK  = 4'd3;
    localparam logic [3:0] OP_READ_NACK = 4'd4;
    localparam logic [3:0] OP_STOP      = 4'd5;
    localparam logic [3:0] OP_DELAY     = 4'd6;
    localparam logic [3:0] OP_WAIT_IRQ  = 4'd7;
    localparam logic [3:0] OP_JUMP      = 4'd8;
    localparam logic [3:0] OP_HALT      = 4'd9;

    state_t      state;
    state_t      state_next;
    logic [7:0]  pc_reg;
    logic [7:0]  pc_next;
    logic [19:0] cnt;
    logic [19:0] cnt_next;
    logic [3:0]  ir_op;
    logic [3:0]  ir_op_next;
    logic        err_nack_next;
    logic        err_illegal_next;
    logic        err_timeout_next;
    logic        cmd_load;
    logic        rd_load;

    assign rom_addr = pc_reg;
    assign pc       = pc_reg;

    // Next-state, next-PC, counter and error-flag decisions; abort overrides everything.
    always_comb begin
        state_next       = state;
        pc_next          = pc_reg;
        cnt_next         = cnt;
        ir_op_next       = ir_op;
        err_nack_next    = err_nack;
        err_illegal_next = err_illegal;
        err_timeout_next = err_timeout;
        cmd_load         = 1'b0;
        rd_load          = 1'b0;

        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_next       = S_FETCH;
                        pc_next          = START_ADDR;
                        err_nack_next    = 1'b0;
                        err_illegal_next = 1'b0;
                        err_timeout_next = 1'b0;
                    end
                end
                S_FETCH: begin
                    state_next = S_DECODE;
                end
                S_DECODE: begin
                    ir_op_next = rom_data[31:28];
                    pc_next    = pc_reg + 8'd1;
                    case (rom_data[31:28])
                        OP_NOP: state_next = S_FETCH;
                        OP_START, OP_WRITE, OP_READ_ACK, OP_READ_NACK, OP_STOP: begin
                            state_next = S_ISSUE;
                            cmd_load   = 1'b1;
                        end
                        OP_DELAY: begin
                            cnt_next   = rom_data[19:0];
                            state_next = (rom_data[19:0] == 20'd0) ? S_FETCH : S_DELAY;
                        end
                        OP_WAIT_IRQ: begin
                            cnt_next   = rom_data[19:0];
                            state_next = S_WAIT_IRQ;
                        end
                        OP_JUMP: begin
                            pc_next    = rom_data[27:20];
                            state_next = S_FETCH;
                        end
                        OP_HALT: state_next = S_HALT;
                        default: begin
                            err_illegal_next = 1'b1;
                            state_next       = S_HALT;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (eng.cmd_ready) begin
                        state_next = S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (eng.rsp_valid) begin
                        if (ir_op == OP_READ_ACK || ir_op == OP_READ_NACK) begin
                            rd_load    = 1'b1;
                            state_next = S_FETCH;
                        end else if (eng.rsp_nack && (ir_op == OP_START || ir_op == OP_WRITE)) begin
                            err_nack_next = 1'b1;
                            state_next    = S_HALT;
                        end else begin
                            state_next = S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt <= 20'd1) begin
                        state_next = S_FETCH;
                    end else begin
                        cnt_next = cnt - 20'd1;
                    end
                end
                S_WAIT_IRQ: begin
                    if (irq) begin
                        state_next = S_FETCH;
                    end else if (cnt != 20'd0) begin
                        if (cnt == 20'd1) begin
                            err_timeout_next = 1'b1;
                            state_next       = S_HALT;
                        end else begin
                            cnt_next = cnt - 20'd1;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs; status outputs track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc_reg        <= 8'd0;
            cnt           <= 20'd0;
            ir_op         <= 4'd0;
            err_nack      <= 1'b0;
            err_illegal   <= 1'b0;
            err_timeout   <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= 8'd0;
            eng.cmd_valid <= 1'b0;
            eng.cmd_op    <= 3'd0;
            eng.cmd_wdata <= 8'd0;
        end else begin
            state         <= state_next;
            pc_reg        <= pc_next;
            cnt           <= cnt_next;
            ir_op         <= ir_op_next;
            err_nack      <= err_nack_next;
            err_illegal   <= err_illegal_next;
            err_timeout   <= err_timeout_next;
            busy          <= (state_next != S_IDLE) && (state_next != S_HALT);
            halted        <= (state_next == S_HALT);
            eng.cmd_valid <= (state_next == S_ISSUE);
            rd_valid      <= rd_load;
            if (rd_load) begin
                rd_data <= eng.rsp_rdata;
            end
            if (cmd_load) begin
                eng.cmd_op    <= rom_data[30:28];
                eng.cmd_wdata <= rom_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_bendlab_seq_ctrl.sv
// Self-checking bench for bendlab_seq_ctrl: ROM model, I2C engine model and
// scoreboard queues for expected commands and expected read bytes.
module tb_bendlab_seq_ctrl;

    typedef struct {
        logic [2:0] op;
        logic [7:0] wdata;
    } cmd_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        irq;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic        halted;
    logic        err_nack;
    logic        err_illegal;
    logic        err_timeout;
    logic [7:0]  pc;

    logic [31:0] rom_mem [256];
    cmd_exp_t    cmd_q [$];
    logic [7:0]  rd_q [$];

    int          check_count = 0;
    int          pass_count  = 0;
    int          rd_pulses   = 0;
    int          rsp_lat     = 3;
    int          ready_wait  = 0;
    logic [7:0]  rsp_byte    = 8'h00;
    logic [2:0]  nack_op     = 3'd0;
    logic        rsp_seen_prev = 1'b0;

    bendlab_seq_ctrl_if eng();

    bendlab_seq_ctrl #(.START_ADDR(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .irq         (irq),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .eng         (eng),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .halted      (halted),
        .err_nack    (err_nack),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Remember whether a completion was sampled at the latest edge
    always @(posedge clk) rsp_seen_prev <= eng.rsp_valid;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [7:0] tgt, input logic [19:0] imm);
        return {op, tgt, imm};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom_mem[i] = ins(4'd9, 8'd0, 20'd0);
    endtask

    task automatic pushCmd(input logic [2:0] op, input logic [7:0] wdata);
        cmd_exp_t e;
        e.op    = op;
        e.wdata = wdata;
        cmd_q.push_back(e);
    endtask

    // Pulses start for one cycle; returns at the falling edge after the start edge
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitHalted(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, halted, 1'b1);
    endtask

    task automatic countBusy(input int irq_at, output int n);
        n = 0;
        while (busy && n < 200) begin
            if (n == irq_at) irq = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    // I2C engine model: checks each issued command against the scoreboard, then replies
    initial begin : engine_model
        int       waited;
        cmd_exp_t e;
        logic [2:0] cap_op;
        eng.cmd_ready = 1'b0;
        eng.rsp_valid = 1'b0;
        eng.rsp_rdata = 8'h00;
        eng.rsp_nack  = 1'b0;
        forever begin
            @(negedge clk);
            if (eng.cmd_valid) begin
                waited = 0;
                while (waited < ready_wait && eng.cmd_valid) begin
                    @(negedge clk);
                    waited++;
                end
                if (eng.cmd_valid) begin
                    if (cmd_q.size() == 0) begin
                        checkOutput("cmd_unexpected", eng.cmd_valid, 1'b0);
                    end else begin
                        e = cmd_q.pop_front();
                        checkOutput("cmd_op", eng.cmd_op, e.op);
                        checkOutput("cmd_wdata", eng.cmd_wdata, e.wdata);
                    end
                    cap_op = eng.cmd_op;
                    eng.cmd_ready = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    eng.cmd_ready = 1'b0;
                    repeat (rsp_lat - 1) @(negedge clk);
                    eng.rsp_valid = 1'b1;
                    eng.rsp_rdata = rsp_byte;
                    eng.rsp_nack  = (nack_op != 3'd0) && (cap_op == nack_op);
                    @(negedge clk);
                    eng.rsp_valid = 1'b0;
                    eng.rsp_nack  = 1'b0;
                end
            end
        end
    end

    // Read monitor: every rd_valid pulse must match a queued byte and follow a completion
    initial begin : rd_monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rd_valid) begin
                rd_pulses++;
                if (rd_q.size() == 0) begin
                    checkOutput("rd_unexpected", rd_valid, 1'b0);
                end else begin
                    checkOutput("rd_data", rd_data, rd_q.pop_front());
                    checkOutput("rd_latency", rsp_seen_prev, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        int pulses_before;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        irq   = 1'b0;
        clearRom();
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
            {rom_addr, pc, eng.cmd_valid, eng.cmd_op, eng.cmd_wdata, rd_valid, rd_data,
             busy, halted, err_nack, err_illegal, err_timeout}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 1'b0);

        // WRITE 0x5A, READ_NACK (its NACK must be ignored), HALT
        clearRom();
        rom_mem[0] = ins(4'd2, 8'd0, 20'h0005A);
        rom_mem[1] = ins(4'd4, 8'd0, 20'd0);
        rsp_lat = 3; ready_wait = 2; rsp_byte = 8'hC3; nack_op = 3'd4;
        pushCmd(3'd2, 8'h5A);
        pushCmd(3'd4, 8'h00);
        rd_q.push_back(8'hC3);
        pulses_before = rd_pulses;
        applyStimulus();
        waitHalted("prog_a_halted", 100);
        checkOutput("prog_a_pc", pc, 8'd3);
        checkOutput("prog_a_errs", {err_nack, err_illegal, err_timeout}, 3'b000);
        checkOutput("prog_a_cmds_left", cmd_q.size(), 0);
        checkOutput("prog_a_rd_pulses", rd_pulses - pulses_before, 1);
        checkOutput("prog_a_rd_hold", rd_data, 8'hC3);
        ready_wait = 0; nack_op = 3'd0;

        // DELAY 5, HALT
        clearRom();
        rom_mem[0] = ins(4'd6, 8'd0, 20'd5);
        applyStimulus();
        countBusy(-1, n);
        checkOutput("delay_busy_cycles", n, 9);
        checkOutput("delay_halted", halted, 1'b1);
        checkOutput("delay_pc", pc, 8'd2);
        checkOutput("delay_errs", {err_nack, err_illegal, err_timeout}, 3'b000);

        // JUMP 0xFF, NOP at 0xFF, then HALT placed at 0 once the jump is decoded
        clearRom();
        rom_mem[0]    = ins(4'd8, 8'hFF, 20'd0);
        rom_mem[8'hFF] = ins(4'd0, 8'd0, 20'd0);
        applyStimulus();
        repeat (2) @(negedge clk);
        checkOutput("jump_target", pc, 8'hFF);
        rom_mem[0] = ins(4'd9, 8'd0, 20'd0);
        repeat (2) @(negedge clk);
        checkOutput("pc_wrap", pc, 8'h00);
        waitHalted("jump_halted", 20);
        checkOutput("jump_pc", pc, 8'd1);

        // WAIT_IRQ with timeout 10 and irq low, then again with irq on the 4th wait cycle
        clearRom();
        rom_mem[0] = ins(4'd7, 8'd0, 20'd10);
        applyStimulus();
        countBusy(-1, n);
        checkOutput("timeout_busy_cycles", n, 12);
        checkOutput("timeout_flag", err_timeout, 1'b1);
        checkOutput("timeout_halted", halted, 1'b1);
        checkOutput("timeout_pc", pc, 8'd1);
        applyStimulus();
        countBusy(5, n);
        irq = 1'b0;
        checkOutput("irq_busy_cycles", n, 8);
        checkOutput("irq_no_timeout", err_timeout, 1'b0);
        checkOutput("irq_pc", pc, 8'd2);

        // START, WRITE 0x77 NACKed, STOP must never be issued
        clearRom();
        rom_mem[0] = ins(4'd1, 8'd0, 20'd0);
        rom_mem[1] = ins(4'd2, 8'd0, 20'h00077);
        rom_mem[2] = ins(4'd5, 8'd0, 20'd0);
        rsp_lat = 2; nack_op = 3'd2;
        pushCmd(3'd1, 8'h00);
        pushCmd(3'd2, 8'h77);
        applyStimulus();
        waitHalted("nack_halted", 100);
        checkOutput("nack_flag", err_nack, 1'b1);
        checkOutput("nack_pc", pc, 8'd2);
        checkOutput("nack_cmds_left", cmd_q.size(), 0);
        nack_op = 3'd0;
        rom_mem[0] = ins(4'd9, 8'd0, 20'd0);
        applyStimulus();
        checkOutput("nack_cleared", err_nack, 1'b0);
        waitHalted("restart_halted", 20);
        checkOutput("restart_pc", pc, 8'd1);

        // Illegal opcode
        rom_mem[0] = 32'hF000_0000;
        applyStimulus();
        waitHalted("illegal_halted", 20);
        checkOutput("illegal_flag", err_illegal, 1'b1);
        checkOutput("illegal_pc", pc, 8'd1);

        // Abort while waiting for a read completion; the late completion must be ignored
        clearRom();
        rom_mem[0] = ins(4'd3, 8'd0, 20'd0);
        rsp_lat = 8; rsp_byte = 8'h11;
        pushCmd(3'd3, 8'h00);
        pulses_before = rd_pulses;
        applyStimulus();
        n = 0;
        while (!eng.cmd_valid && n < 20) begin @(negedge clk); n++; end
        while (eng.cmd_valid && n < 40) begin @(negedge clk); n++; end
        checkOutput("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_cmd_valid", eng.cmd_valid, 1'b0);
        checkOutput("abort_idle", {busy, halted}, 2'b00);
        checkOutput("abort_pc", pc, 8'd1);
        repeat (14) @(negedge clk);
        checkOutput("abort_no_rd", rd_pulses - pulses_before, 0);
        checkOutput("abort_still_idle", busy, 1'b0);

        // Reset asserted mid-DELAY, with a start pulse during DELAY ignored first
        clearRom();
        rom_mem[0] = ins(4'd6, 8'd0, 20'd20);
        applyStimulus();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_ignored_pc", pc, 8'd1);
        checkOutput("start_ignored_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
            {rom_addr, pc, eng.cmd_valid, eng.cmd_op, eng.cmd_wdata, rd_valid, rd_data,
             busy, halted, err_nack, err_illegal, err_timeout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
